// File: rtl/sha256_multi_engine.sv
// Multi-block SHA-256 / SHA-224 engine: streams a word-aligned message from a shared
// single-port memory, pads it on the fly and writes the digest back to the same memory.
module sha256_multi_engine #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [15:0]       num_words_i,
  input  logic [ADDR_W-1:0] message_addr_i,
  input  logic [ADDR_W-1:0] output_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_clk_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_write_data_o,
  input  logic [31:0]       mem_read_data_i
);

  typedef enum logic [2:0] {StIdle, StFetch, StRounds, StUpdate, StWrite, StDone} state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] Iv256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] Iv224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_e            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [12:0]       blk_q, blk_d, nblk_q, nblk_d;
  logic [15:0]       nw_q, nw_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] msg_q, msg_d, out_q, out_d;
  logic [31:0]       h_q [8];
  logic [31:0]       h_d [8];
  logic [31:0]       wv_q [8];
  logic [31:0]       wv_d [8];
  logic [31:0]       w_q [16];
  logic [31:0]       w_d [16];
  logic              busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [15:0] nw_clamp;
  logic [12:0] nblk_in;
  logic [16:0] nw17, cap_idx, last_idx, fetch_nxt, upd_nxt;
  logic [31:0] cap_word, sched, t1, t2;

  assign nw_clamp  = (32'(num_words_i) > MAX_WORDS) ? 16'(MAX_WORDS) : num_words_i;
  assign nblk_in   = 13'((17'(nw_clamp) + 17'd2) >> 4) + 13'd1;
  assign nw17      = 17'(nw_q);
  // Stream index of the word arriving this cycle (address was presented one cycle earlier).
  assign cap_idx   = {blk_q, 4'b0} + 17'(cnt_q) - 17'd1;
  assign last_idx  = {nblk_q, 4'b0} - 17'd1;
  assign fetch_nxt = {blk_q, 4'b0} + 17'(cnt_q) + 17'd1;
  assign upd_nxt   = {blk_q + 13'd1, 4'b0};

  always_comb begin
    if (cap_idx < nw17) begin
      cap_word = mem_read_data_i;
    end else if (cap_idx == nw17) begin
      cap_word = 32'h8000_0000;
    end else if (cap_idx == last_idx) begin
      cap_word = {11'd0, nw_q, 5'd0};
    end else begin
      cap_word = '0;
    end
  end

  assign sched = w_q[0] + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[9]
               + (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10));
  assign t1 = wv_q[7] + (rotr(wv_q[4], 6) ^ rotr(wv_q[4], 11) ^ rotr(wv_q[4], 25))
            + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6])) + K[cnt_q[5:0]] + w_q[0];
  assign t2 = (rotr(wv_q[0], 2) ^ rotr(wv_q[0], 13) ^ rotr(wv_q[0], 22))
            + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    nblk_d  = nblk_q;
    nw_d    = nw_q;
    mode_d  = mode_q;
    msg_d   = msg_q;
    out_d   = out_q;
    h_d     = h_q;
    wv_d    = wv_q;
    w_d     = w_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          nw_d    = nw_clamp;
          nblk_d  = nblk_in;
          mode_d  = mode_i;
          msg_d   = message_addr_i;
          out_d   = output_addr_i;
          h_d     = mode_i ? Iv224 : Iv256;
          blk_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StFetch;
          // Address is held when there is no message word to read.
          if (nw_clamp != 16'd0) addr_d = message_addr_i;
        end
      end
      StFetch: begin
        if (cnt_q != 7'd0) begin
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
          w_d[15] = cap_word;
        end
        if (cnt_q == 7'd16) begin
          cnt_d   = '0;
          wv_d    = h_q;
          state_d = StRounds;
        end else begin
          cnt_d = cnt_q + 7'd1;
          if (cnt_q < 7'd15 && fetch_nxt < nw17) addr_d = msg_q + ADDR_W'(fetch_nxt);
        end
      end
      StRounds: begin
        wv_d = '{t1 + t2, wv_q[0], wv_q[1], wv_q[2], wv_q[3] + t1, wv_q[4], wv_q[5], wv_q[6]};
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = sched;
        if (cnt_q == 7'd63) begin
          cnt_d   = '0;
          state_d = StUpdate;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StUpdate: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
        cnt_d = '0;
        if (blk_q + 13'd1 < nblk_q) begin
          blk_d   = blk_q + 13'd1;
          state_d = StFetch;
          if (upd_nxt < nw17) addr_d = msg_q + ADDR_W'(upd_nxt);
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        we_d    = 1'b1;
        addr_d  = out_q + ADDR_W'(cnt_q);
        wdata_d = h_q[cnt_q[2:0]];
        if (cnt_q == (mode_q ? 7'd6 : 7'd7)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      blk_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    nblk_q <= nblk_d;
    nw_q   <= nw_d;
    mode_q <= mode_d;
    msg_q  <= msg_d;
    out_q  <= out_d;
    h_q    <= h_d;
    wv_q   <= wv_d;
    w_q    <= w_d;
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign mem_clk_o        = clk_i;
  assign mem_we_o         = we_q;
  assign mem_addr_o       = addr_q;
  assign mem_write_data_o = wdata_q;

endmodule

// File: tb/tb_sha256_multi_engine.sv
// Directed bench for sha256_multi_engine: vector table plus busy-start and mid-run reset cases,
// with a behavioural SHA-256/224 reference for the generated-data messages.
module tb_sha256_multi_engine;

  logic        clk, reset, start, mode;
  logic [15:0] num_words, message_addr, output_addr;
  logic        busy, done, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;

  sha256_multi_engine #(.ADDR_W(16), .MAX_WORDS(1024)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (start),
    .mode_i          (mode),
    .num_words_i     (num_words),
    .message_addr_i  (message_addr),
    .output_addr_i   (output_addr),
    .busy_o          (busy),
    .done_o          (done),
    .mem_clk_o       (mem_clk),
    .mem_we_o        (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_write_data_o(mem_write_data),
    .mem_read_data_i (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [255:0] EMPTY256 =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  // Memory model: read-only message image, write log with per-address write stamps.
  logic [31:0] rom   [65536];
  logic [31:0] wmem  [65536];
  int          wstamp[65536];
  int          wr_total, rd_events, rd_bad;
  logic [15:0] prev_addr, cur_msg;
  int          cur_nw;

  always @(posedge clk) begin
    mem_read_data <= rom[mem_addr];
    if (mem_we) begin
      wr_total = wr_total + 1;
      wmem[mem_addr]   <= mem_write_data;
      wstamp[mem_addr] <= wr_total;
    end
    if (busy && !mem_we && mem_addr != prev_addr) begin
      rd_events = rd_events + 1;
      if (int'(16'(mem_addr - cur_msg)) >= cur_nw) rd_bad = rd_bad + 1;
    end
    prev_addr <= mem_addr;
  end

  int n_tests, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] xx;
    xx = {x, x} >> n;
    return xx[31:0];
  endfunction

  function automatic logic [31:0] gen_word(input logic [31:0] seed, input int i);
    if (seed == 32'd0) return 32'h61626364;
    return (seed ^ (32'(i) * 32'h9e3779b9)) + 32'(i);
  endfunction

  logic [31:0]  msg_buf[64];
  logic [31:0]  pad_buf[128];
  logic [255:0] exp_dig;

  task automatic sha_model(input int nw, input bit m);
    int nb;
    logic [31:0] hh[8];
    logic [31:0] ww[64];
    logic [31:0] a, b, c, d, e, f, g, h, x1, x2;
    logic [255:0] iv;
    nb = (nw * 4 + 9 + 63) / 64;
    for (int i = 0; i < nb * 16; i++)
      pad_buf[i] = (i < nw) ? msg_buf[i] : ((i == nw) ? 32'h8000_0000 : 32'h0);
    pad_buf[nb*16-1] = 32'(nw * 32);
    iv = m ? IV224 : IV256;
    for (int i = 0; i < 8; i++) hh[i] = iv[255-32*i -: 32];
    for (int bk = 0; bk < nb; bk++) begin
      for (int i = 0; i < 16; i++) ww[i] = pad_buf[bk*16+i];
      for (int i = 16; i < 64; i++)
        ww[i] = (ror(ww[i-2], 17) ^ ror(ww[i-2], 19) ^ (ww[i-2] >> 10)) + ww[i-7]
              + (ror(ww[i-15], 7) ^ ror(ww[i-15], 18) ^ (ww[i-15] >> 3)) + ww[i-16];
      a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3]; e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
      for (int t = 0; t < 64; t++) begin
        x1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + ww[t];
        x2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
      end
      hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
      hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
    end
    exp_dig = {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
  endtask

  // Starts a run and counts edges after the start-sampling edge until done is seen.
  task automatic do_run(input bit m, input int nw, input logic [15:0] ma, input logic [15:0] oa,
                        input bit perturb, input int abort_at, output int lat);
    @(negedge clk);
    mode = m; num_words = 16'(nw); message_addr = ma; output_addr = oa; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    lat = -1;
    for (int c = 1; c <= 5000; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
      if (perturb && c >= 30 && c <= 35) begin
        start = 1'b1; mode = ~m; num_words = 16'd5;
        message_addr = 16'h4000; output_addr = 16'h4100;
      end else begin
        start = 1'b0;
      end
      if (c == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        lat = -2;
        break;
      end
    end
    if (lat > 0) check("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    bit           mode;
    int           nw;
    logic [15:0]  msg;
    logic [15:0]  outa;
    logic [31:0]  seed;
    bit           use_model;
    int           exp_cyc;
    logic [255:0] dig;
  } vec_t;

  vec_t vecs[7];

  task automatic verify_digest(input string tag, input logic [15:0] oa, input int ow,
                               input int wr0);
    logic [15:0] a;
    for (int n = 0; n < ow; n++) begin
      a = oa + 16'(n);
      check($sformatf("%s.digest%0d", tag, n), wmem[a], exp_dig[255-32*n -: 32]);
      check($sformatf("%s.fresh%0d", tag, n), {31'd0, wstamp[a] > wr0}, 32'd1);
    end
  endtask

  initial begin
    int lat, ow, wr0, rd0, bad0;
    vec_t v;
    n_tests = 0; n_fail = 0;
    wr_total = 0; rd_events = 0; rd_bad = 0;
    cur_msg = '0; cur_nw = 0;
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    num_words = '0; message_addr = '0; output_addr = '0;
    for (int i = 0; i < 65536; i++) rom[i] = 32'hc0de_0000 | 32'(i);

    vecs[0] = '{1'b0, 0,  16'h0100, 16'h2000, 32'h0, 1'b0, 91, EMPTY256};
    vecs[1] = '{1'b1, 0,  16'h0100, 16'h2100, 32'h0, 1'b0, 90,
      256'hd14a028c_2a3a2bc9_476102bb_288234c4_15a2b01f_828ea62a_c5b3e42f_00000000};
    vecs[2] = '{1'b0, 1,  16'h0200, 16'h2200, 32'h0, 1'b0, 91,
      256'h88d4266f_d4e6338d_13b845fc_f289579d_209c8978_23b9217d_a3e16193_6f031589};
    vecs[3] = '{1'b0, 13, 16'h0300, 16'h2300, 32'h1111_2222, 1'b1, 91,  '0};
    vecs[4] = '{1'b0, 14, 16'h0400, 16'h2400, 32'h3333_4444, 1'b1, 173, '0};
    vecs[5] = '{1'b0, 20, 16'hfff4, 16'h2500, 32'h5555_6666, 1'b1, 173, '0};
    vecs[6] = '{1'b1, 3,  16'h0600, 16'hfffd, 32'h7777_8888, 1'b1, 90,  '0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_we", {31'd0, mem_we}, 32'd0);
    check("reset_addr", {16'd0, mem_addr}, 32'd0);
    check("reset_wdata", mem_write_data, 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 7; k++) begin
      v = vecs[k];
      for (int i = 0; i < v.nw; i++) begin
        msg_buf[i] = gen_word(v.seed, i);
        rom[16'(v.msg + 16'(i))] = msg_buf[i];
      end
      if (v.use_model) sha_model(v.nw, v.mode);
      else exp_dig = v.dig;
      ow = v.mode ? 7 : 8;
      cur_msg = v.msg; cur_nw = v.nw;
      wr0 = wr_total; rd0 = rd_events; bad0 = rd_bad;
      do_run(v.mode, v.nw, v.msg, v.outa, 1'b0, 0, lat);
      check($sformatf("v%0d.latency", k), 32'(lat), 32'(v.exp_cyc));
      check($sformatf("v%0d.writes", k), 32'(wr_total - wr0), 32'(ow));
      check($sformatf("v%0d.reads_out_of_range", k), 32'(rd_bad - bad0), 32'd0);
      if (v.nw == 0) check($sformatf("v%0d.reads_empty", k), 32'(rd_events - rd0), 32'd0);
      verify_digest($sformatf("v%0d", k), v.outa, ow, wr0);
      if (v.mode)
        check($sformatf("v%0d.h7_untouched", k),
              {31'd0, wstamp[16'(v.outa + 16'd7)] > wr0}, 32'd0);
    end

    // start re-pulsed and inputs changed while busy must not disturb the run.
    for (int i = 0; i < 14; i++) begin
      msg_buf[i] = gen_word(32'h9999_aaaa, i);
      rom[16'h0700 + 16'(i)] = msg_buf[i];
    end
    sha_model(14, 1'b0);
    cur_msg = 16'h0700; cur_nw = 14;
    wr0 = wr_total; bad0 = rd_bad;
    do_run(1'b0, 14, 16'h0700, 16'h2700, 1'b1, 0, lat);
    check("busy_start.latency", 32'(lat), 32'd173);
    check("busy_start.writes", 32'(wr_total - wr0), 32'd8);
    check("busy_start.reads_out_of_range", 32'(rd_bad - bad0), 32'd0);
    check("busy_start.no_alt_write", {31'd0, wstamp[16'h4100] > wr0}, 32'd0);
    verify_digest("busy_start", 16'h2700, 8, wr0);

    // Reset during block 2 rounds, then an empty-message run.
    for (int i = 0; i < 20; i++) rom[16'h0800 + 16'(i)] = gen_word(32'hbbbb_cccc, i);
    cur_msg = 16'h0800; cur_nw = 20;
    wr0 = wr_total;
    do_run(1'b0, 20, 16'h0800, 16'h2800, 1'b0, 120, lat);
    check("abort.reached", 32'(lat), 32'hffff_fffe);
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.we", {31'd0, mem_we}, 32'd0);
    check("abort.done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("abort.no_writes", 32'(wr_total - wr0), 32'd0);
    exp_dig = EMPTY256;
    cur_msg = 16'h0900; cur_nw = 0;
    rd0 = rd_events;
    do_run(1'b0, 0, 16'h0900, 16'h2900, 1'b0, 0, lat);
    check("after_abort.latency", 32'(lat), 32'd91);
    check("after_abort.writes", 32'(wr_total - wr0), 32'd8);
    check("after_abort.reads", 32'(rd_events - rd0), 32'd0);
    check("after_abort.old_out", {31'd0, wstamp[16'h2800] > wr0}, 32'd0);
    verify_digest("after_abort", 16'h2900, 8, wr0);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_multi_engine.md
Name: sha256_multi_engine

Overview:
- Successor to the fixed-size, single-purpose SHA-256 core. It hashes a word-aligned message of runtime-selected length (0..MAX_WORDS 32-bit words) held in word-addressed memory.
- It builds standard SHA-256 padding on the fly across any number of 512-bit blocks and streams message words instead of buffering the whole message.
- A mode input selects SHA-256 (8 output words) or SHA-224 (7 output words). The digest is written back through the same shared single-port memory interface.

Parameters:
- ADDR_W, 16, memory word-address width.
- MAX_WORDS, 1024, largest legal num_words. Larger values are clamped to MAX_WORDS.

Ports:
- clk  in  1  system clock; mem_clk is a copy of it.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  1  0 = SHA-256, 1 = SHA-224; latched at start.
- num_words  in  16  message length in 32-bit words; latched at start.
- message_addr  in  ADDR_W  base word address of the message; latched at start.
- output_addr  in  ADDR_W  base word address of the digest; latched at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last digest word has been written.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_write_data  out  32  memory write data.
- mem_read_data  in  32  read data, valid one cycle after the address is presented.

Behaviour:
- Reset (synchronous, active-high): state = IDLE, busy = 0, done = 0, mem_we = 0, mem_addr = 0, mem_write_data = 0. Reset mid-operation aborts immediately; no further writes are issued.
- Block count: nblocks = floor((num_words + 2)/16) + 1. Examples: 0 -> 1, 13 -> 1, 14 -> 2, 20 -> 2.
- Padded stream, word index p:
  - p < num_words: memory word at message_addr + p.
  - p = num_words: 0x80000000.
  - Last two words of the final block: length in bits as 64 bits. High word = 0; low word = num_words << 5 (the 16-bit count times 32 fits in 21 bits).
  - All other words: 0.
- Initial hash:
  - SHA-256: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - SHA-224: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
- States: IDLE -> FETCH -> ROUNDS -> UPDATE -> (FETCH for the next block | WRITE) -> DONE -> IDLE.
- IDLE: start = 1 latches all inputs, loads H0..H7, and moves to FETCH next cycle. start at any other time is ignored.
- FETCH, 17 cycles per block:
  - Cycles 0..15 present mem_addr = message_addr + p with mem_we = 0.
  - Cycles 1..16 capture mem_read_data, or the substituted pad/length word, into W[0..15].
  - Reads are suppressed (address held) for pad-only words. Memory beyond message_addr + num_words - 1 is never read.
- ROUNDS, 64 cycles:
  - One compression round per cycle using W[0] and K[t], t = 0..63.
  - Message schedule via a 16-entry shift register: new W[15] = W[0] + s0(W[1]) + W[9] + s1(W[14]).
  - a..h are loaded from H0..H7 at the first round cycle.
- UPDATE, 1 cycle: Hi <= Hi + {a..h}[i], all mod 2^32. If blocks remain, go to FETCH; otherwise go to WRITE.
- WRITE: one word per cycle with mem_we = 1, mem_addr = output_addr + n, mem_write_data = Hn. n runs 0..7 for SHA-256 and 0..6 for SHA-224, so H7 is never written in SHA-224.
- DONE: 1 cycle with done = 1, busy = 0, mem_we = 0, then IDLE.
- Latency: done is high exactly 82*nblocks + OUT_WORDS + 1 cycles after the start-sampling edge (OUT_WORDS = 8 or 7).
- Arithmetic is all modulo 2^32. Address arithmetic wraps modulo 2^ADDR_W.
- mem_we is high only in WRITE.

Test Plan:
- num_words = 0, mode = 0 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 at output_addr..+7; done at cycle 91; zero memory reads.
- num_words = 0, mode = 1 -> digest d14a028c 2a3a2bc9 476102bb 288234c4 15a2b01f 828ea62a c5b3e42f; exactly 7 writes; output_addr + 7 unchanged.
- num_words = 1, word 0x61626364 ("abcd"), mode = 0 -> 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589.
- num_words = 13, 14, 20 (random data) -> 1, 2, 2 blocks; done at cycles 91, 173, 173; digests match the software model; only addresses message_addr..+num_words-1 are read.
- start pulsed while busy, plus mode/addr inputs changed mid-run -> ignored; digest and timing unchanged.
- reset asserted during ROUNDS of block 2, then a new start with num_words = 0 -> no writes before the new run; the empty-string digest is correct.
